icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  N-way set-associative instruction cache with multi-word lines; replaces the direct-mapped single-word icache.
//  Sits between IFetch and the memory controller. Hit lookup is same-cycle combinational.
//  On a miss it runs its own line-refill FSM. Supports a whole-cache flush (fence.i / branch reset).
// PARAMETERS
//  INDEX_WIDTH  6  log2(sets); sets = 2**INDEX_WIDTH
//  WAYS         2  associativity; legal 1, 2, 4
//  OFFSET_WIDTH 2  log2(words per line); line = 2**OFFSET_WIDTH 32-bit words
//  (derived) TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH
// PORTS
//  clk        in   1   clock, posedge
//  rst        in   1   asynchronous reset, active-high
//  rdy        in   1   global ready; 0 freezes all state (FSM, arrays, counters)
//  fetch_en   in   1   IFetch lookup request valid
//  fetch_addr in   32  byte address of instruction; bits[1:0] ignored
//  hit        out  1   fetch_en && valid way tag-match on fetch_addr (combinational)
//  inst_out   out  32  matching word; 0 when !hit
//  busy       out  1   FSM not IDLE (refill in progress)
//  flush      in   1   invalidate every line
//  mem_req    out  1   word-fetch request to memory controller, held until mem_rdy
//  mem_addr   out  32  word address being fetched (bits[1:0]=0)
//  mem_rdy    in   1   one-cycle pulse: mem_data valid for current mem_addr
//  mem_data   in   32  returned word
// BEHAVIOUR
//  Address split: tag=[31:IW+OW+2], index=[IW+OW+1:OW+2], offset=[OW+1:2].
//  Reset: all valid=0, all victim pointers=0, FSM=IDLE; outputs hit=0, inst_out=0, busy=0, mem_req=0, mem_addr=0.
//  Data/tag arrays not reset (valid gates them).
//  Lookup: compare tag in all WAYS of set; >1 match impossible by construction.
//  FSM IDLE: fetch_en && !hit && !flush -> REFILL.
//    Latch line base = {tag,index,OW'b0,2'b0} and set/tag.
//    Choose victim: lowest-numbered invalid way, else victim_ptr[set]. Cycle after miss: mem_req=1, mem_addr=base.
//  FSM REFILL: hold mem_req/mem_addr until mem_rdy. On mem_rdy, write mem_data into word counter of victim line.
//    Counter+1, mem_addr+4. Next request issued the following cycle (mem_req stays 1).
//    On last word (counter wraps 2**OW-1 -> 0): set valid, write tag, victim_ptr[set] += 1 mod WAYS (only if all ways were valid).
//    mem_req drops, -> IDLE. Line is visible to lookup the cycle after last write (no bypass of mem_data to inst_out).
//  During REFILL, hit still reports for other lines (hit-under-miss). The refilling line's valid stays 0 until complete.
//  fetch_addr changes during REFILL do not alter the refill in progress.
//  Flush: in IDLE, clears all valid bits next edge; hit is forced 0 in the flush cycle.
//    In REFILL: same clear, refill aborted, FSM -> IDLE, mem_req deasserts next cycle.
//    An outstanding mem_rdy arriving after abort is ignored.
//  Flush and miss in same cycle: flush wins, no refill starts.
//  mem_rdy while IDLE: ignored. rdy=0: no state changes, mem_req/mem_addr hold.
//  Async rst mid-refill: immediate return to reset state. mem_req=0 without waiting for mem_rdy.
//  WAYS=1: behaves as direct-mapped with line refill; victim_ptr unused.
// TESTING
//  1 Reset, fetch_en=1 addr 0x0000_1000 -> hit=0, next cycle mem_req=1 mem_addr=0x1000. Respond 4 words 0xA0..0xA3 -> addr 0x1000..0x100C hit=1, inst_out=0xA0..0xA3.
//  2 WAYS=2: fill 0x1000, then 0x2000 (same set 0, different tag) -> both hit. Miss 0x3000 evicts way0 (0x1000 misses). Next conflict 0x4000 evicts way1.
//  3 Refill 0x1000 with mem_rdy after 3-cycle gaps and rdy=0 for 2 cycles mid-refill -> mem_addr holds each word until mem_rdy. Final line correct.
//  4 Assert flush on 2nd word of refill -> busy=0 next cycle, mem_req=0, late mem_rdy ignored, 0x1000 and all prior lines miss.
//  5 Hit-under-miss: refilling 0x2000 while fetch 0x1000 (valid) -> hit=1 inst_out correct. Fetch 0x2004 -> hit=0 until line done.
//  6 Async rst pulse mid-cycle during refill -> mem_req and busy fall without clock edge. All lookups miss afterwards.

Source files
------------

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with multi-word lines and an internal line-refill FSM.
// Latency: hit lookup is same-cycle combinational; a miss issues its first mem_req on the next cycle.
// Backpressure: rdy=0 freezes all state; each refill word is held on mem_req/mem_addr until a mem_rdy pulse.
//
// Ports:
//   clk, rst        clock (posedge), asynchronous active-high reset
//   rdy             global ready; low freezes FSM, arrays and counters
//   fetch_en/addr   IFetch lookup request and byte address (bits [1:0] ignored)
//   hit/inst_out    combinational lookup result; inst_out is 0 when there is no hit
//   busy            refill in progress
//   flush           invalidate every line; also aborts an in-flight refill
//   mem_req/addr    word fetch to the memory controller, held until mem_rdy
//   mem_rdy/data    one-cycle response pulse carrying the word for mem_addr
`timescale 1ns/1ps
module icache_sa #(
  parameter int INDEX_WIDTH  = 6,
  parameter int WAYS         = 2,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_en,
  input  logic [31:0] fetch_addr,
  output logic        hit,
  output logic [31:0] inst_out,
  output logic        busy,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data
);

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << OFFSET_WIDTH;
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state;

  // Valid bits and victim pointers are reset; tag/data arrays are gated by valid.
  logic [SETS-1:0][WAYS-1:0]  valid;
  logic [SETS-1:0][WAY_W-1:0] victim_ptr;
  logic [TAG_WIDTH-1:0]       tag_arr  [SETS][WAYS];
  logic [31:0]                data_arr [SETS][WAYS][WORDS];

  // Refill context, latched at miss time so fetch_addr may move during refill.
  logic [INDEX_WIDTH-1:0]  r_idx;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [WAY_W-1:0]        r_way;
  logic                    r_allv;
  logic [OFFSET_WIDTH-1:0] cnt;

  logic [TAG_WIDTH-1:0]    f_tag;
  logic [INDEX_WIDTH-1:0]  f_idx;
  logic [OFFSET_WIDTH-1:0] f_off;
  logic                    match;
  logic [WAY_W-1:0]        match_way;
  logic [WAY_W-1:0]        victim;
  logic                    all_valid;
  logic                    unused_addr_bits;

  assign f_tag = fetch_addr[31 -: TAG_WIDTH];
  assign f_idx = fetch_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
  assign f_off = fetch_addr[2 +: OFFSET_WIDTH];
  assign unused_addr_bits = ^fetch_addr[1:0];

  // Tags within a set are unique because a line is only refilled after missing.
  always_comb begin
    match     = 1'b0;
    match_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[f_idx][w] && (tag_arr[f_idx][w] == f_tag)) begin
        match     = 1'b1;
        match_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the round-robin pointer.
  always_comb begin
    all_valid = &valid[f_idx];
    victim    = victim_ptr[f_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[f_idx][w]) victim = WAY_W'(w);
    end
  end

  assign hit      = fetch_en && !flush && match;
  assign inst_out = hit ? data_arr[f_idx][match_way][f_off] : 32'd0;
  assign busy     = (state == REFILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      cnt        <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_way      <= '0;
      r_allv     <= 1'b0;
      valid      <= '0;
      victim_ptr <= '0;
    end else if (rdy) begin
      if (flush) begin
        // Flush also aborts a refill; a later mem_rdy lands in IDLE and is ignored.
        valid   <= '0;
        state   <= IDLE;
        mem_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fetch_en && !match) begin
              state    <= REFILL;
              mem_req  <= 1'b1;
              mem_addr <= {fetch_addr[31:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
              r_idx    <= f_idx;
              r_tag    <= f_tag;
              r_way    <= victim;
              r_allv   <= all_valid;
              cnt      <= '0;
              // The victim's old contents get overwritten word by word, so it
              // must stop hitting now rather than when the new line completes.
              valid[f_idx][victim] <= 1'b0;
            end
          end
          REFILL: begin
            if (mem_rdy) begin
              cnt      <= cnt + 1'b1;
              mem_addr <= mem_addr + 32'd4;
              if (cnt == '1) begin
                valid[r_idx][r_way] <= 1'b1;
                if (WAYS > 1 && r_allv) victim_ptr[r_idx] <= victim_ptr[r_idx] + WAY_W'(1);
                mem_req <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag/data storage carries no reset; it is only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (rdy && !flush && (state == REFILL) && mem_rdy) begin
      data_arr[r_idx][r_way][cnt] <= mem_data;
      if (cnt == '1) tag_arr[r_idx][r_way] <= r_tag;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
`timescale 1ns/1ps
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        hit;
  logic [31:0] inst_out;
  logic        busy;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy  = 1'b0;
  logic [31:0] mem_data = '0;

  icache_sa #(.INDEX_WIDTH(6), .WAYS(2), .OFFSET_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .hit(hit), .inst_out(inst_out), .busy(busy), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];   // expected lookup results
  logic [31:0] mexp_q[$];  // expected memory request addresses

  int resp_gap   = 0;
  int stray_cnt  = 0;
  int stray_done = 0;
  int wait_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Lookup monitor: every enabled fetch cycle consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lookup_unexpected addr=%h hit=%b", fetch_addr, hit);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("hit@%h", e.addr), {31'd0, hit}, {31'd0, e.hit});
        check($sformatf("inst@%h", e.addr), inst_out, e.data);
      end
    end
  end

  // Memory responder: word at address a holds 0xA000_0000 | a. Checks that the
  // requested address is the expected one on every cycle it is presented.
  always @(negedge clk) begin
    mem_rdy = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (stray_done < stray_cnt) begin
      stray_done++;
      mem_rdy  = 1'b1;
      mem_data = 32'hDEAD_BEEF;
    end else if (mem_req) begin
      if (mexp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_req_unexpected addr=%h", mem_addr);
      end else begin
        check("mem_addr", mem_addr, mexp_q[0]);
      end
      if (rdy && wait_cnt >= resp_gap && mexp_q.size() != 0) begin
        mem_rdy  = 1'b1;
        mem_data = mem_addr | 32'hA000_0000;
        void'(mexp_q.pop_front());
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic lookup(input logic [31:0] a, input logic eh, input logic [31:0] ed);
    exp_t e;
    @(posedge clk); #1;
    fetch_en   = 1'b1;
    flush      = 1'b0;
    fetch_addr = a;
    e.hit = eh; e.data = ed; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      fetch_en = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Issue a missing lookup and expect n word fetches of its line.
  task automatic miss_start(input logic [31:0] a, input int n);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < n; i++) mexp_q.push_back(base + 32'(4 * i));
    lookup(a, 1'b0, 32'd0);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    check("busy_after_miss", {31'd0, busy}, 32'd1);
    check("mem_req_after_miss", {31'd0, mem_req}, 32'd1);
    check("mem_addr_first", mem_addr, base);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL wait_idle: busy still %b after 200 cycles", busy);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_addr == a) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL wait_addr: mem_addr %h never reached %h", mem_addr, a);
    end
  endtask

  task automatic fill(input logic [31:0] a);
    miss_start(a, 4);
    wait_idle();
  endtask

  // Lookup with flush in the same cycle: forced miss and no refill may start.
  task automatic flush_cycle(input logic [31:0] a);
    lookup(a, 1'b0, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    fetch_en = 1'b0;
    check("flush_wins_busy", {31'd0, busy}, 32'd0);
    check("flush_wins_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; fetch_en = 1'b0; flush = 1'b0; fetch_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    lookup(32'h0000_1000, 1'b0, 32'd0);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    rst = 1'b0;
    idle(1);

    // 1: first miss and line fill
    resp_gap = 0;
    fill(32'h0000_1000);
    lookup(32'h0000_1000, 1'b1, 32'hA000_1000);
    lookup(32'h0000_1004, 1'b1, 32'hA000_1004);
    lookup(32'h0000_1008, 1'b1, 32'hA000_1008);
    lookup(32'h0000_100C, 1'b1, 32'hA000_100C);
    idle(1);

    // 2: two ways in set 0, then round-robin eviction
    fill(32'h0000_2000);
    lookup(32'h0000_1004, 1'b1, 32'hA000_1004);
    lookup(32'h0000_2008, 1'b1, 32'hA000_2008);
    idle(1);
    fill(32'h0000_3000);               // evicts way0 (0x1000)
    lookup(32'h0000_300C, 1'b1, 32'hA000_300C);
    lookup(32'h0000_2000, 1'b1, 32'hA000_2000);
    idle(1);
    resp_gap = 3;
    miss_start(32'h0000_4000, 4);      // evicts way1 (0x2000)
    lookup(32'h0000_1000, 1'b0, 32'd0);
    lookup(32'h0000_2000, 1'b0, 32'd0);
    lookup(32'h0000_3004, 1'b1, 32'hA000_3004);
    lookup(32'h0000_4000, 1'b0, 32'd0);
    idle(1);
    wait_idle();
    lookup(32'h0000_4008, 1'b1, 32'hA000_4008);
    lookup(32'h0000_3008, 1'b1, 32'hA000_3008);
    idle(1);

    // 3: gapped responses with rdy low mid-refill
    flush_cycle(32'h0000_4000);
    resp_gap = 3;
    miss_start(32'h0000_1000, 4);
    wait_addr(32'h0000_1008);
    rdy = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("frozen_mem_addr", mem_addr, 32'h0000_1008);
      check("frozen_mem_req", {31'd0, mem_req}, 32'd1);
    end
    rdy = 1'b1;
    wait_idle();
    lookup(32'h0000_1000, 1'b1, 32'hA000_1000);
    lookup(32'h0000_1004, 1'b1, 32'hA000_1004);
    lookup(32'h0000_1008, 1'b1, 32'hA000_1008);
    lookup(32'h0000_100C, 1'b1, 32'hA000_100C);
    idle(1);

    // 4: flush aborts a refill on its second word; late mem_rdy ignored
    resp_gap = 6;
    miss_start(32'h0000_2000, 2);
    wait_addr(32'h0000_2004);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    stray_cnt++;
    idle(2);
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_mem_req", {31'd0, mem_req}, 32'd0);
    mexp_q.delete();
    resp_gap = 0;
    fill(32'h0000_1000);               // previously valid, must miss after flush
    fill(32'h0000_2000);
    lookup(32'h0000_2004, 1'b1, 32'hA000_2004);
    lookup(32'h0000_1008, 1'b1, 32'hA000_1008);
    idle(1);

    // 5: hit-under-miss
    flush_cycle(32'h0000_1000);
    fill(32'h0000_1000);
    resp_gap = 3;
    miss_start(32'h0000_2000, 4);
    lookup(32'h0000_1000, 1'b1, 32'hA000_1000);
    lookup(32'h0000_100C, 1'b1, 32'hA000_100C);
    lookup(32'h0000_2004, 1'b0, 32'd0);
    idle(1);
    lookup(32'h0000_2004, 1'b0, 32'd0);
    lookup(32'h0000_1008, 1'b1, 32'hA000_1008);
    idle(1);
    wait_idle();
    lookup(32'h0000_2004, 1'b1, 32'hA000_2004);
    idle(1);

    // 6: asynchronous reset during refill
    resp_gap = 6;
    miss_start(32'h0000_3000, 4);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    mexp_q.delete();
    lookup(32'h0000_1000, 1'b0, 32'd0);
    lookup(32'h0000_2004, 1'b0, 32'd0);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    rst = 1'b0;
    idle(1);
    resp_gap = 0;
    fill(32'h0000_1000);
    lookup(32'h0000_1004, 1'b1, 32'hA000_1004);
    idle(2);

    check("lookup_queue_drained", exp_q.size(), 32'd0);
    check("mem_queue_drained", mexp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
